// File: rtl/triangle_area_pipe_if.sv
// Triangle area pipeline bus: upstream valid/ready with vertex data, tag and cull mode,
// downstream valid/ready with area result, plus the cull counter and its clear.
interface triangle_area_pipe_if #(
    parameter int COORD_WIDTH = 17,
    parameter int TAG_WIDTH   = 8,
    parameter int COUNT_WIDTH = 16
);
    logic                                 valid_in;
    logic                                 ready_out;
    logic [2:0][1:0][COORD_WIDTH-1:0]     vertices_in;
    logic [TAG_WIDTH-1:0]                 tag_in;
    logic [1:0]                           cull_mode_in;
    logic                                 valid_out;
    logic                                 ready_in;
    logic [2*COORD_WIDTH-1:0]             area_out;
    logic                                 negative_out;
    logic [TAG_WIDTH-1:0]                 tag_out;
    logic [COUNT_WIDTH-1:0]               cull_count_out;
    logic                                 clear_count_in;

    modport slave (
        input  valid_in, vertices_in, tag_in, cull_mode_in, ready_in, clear_count_in,
        output ready_out, valid_out, area_out, negative_out, tag_out, cull_count_out
    );

    modport master (
        output valid_in, vertices_in, tag_in, cull_mode_in, ready_in, clear_count_in,
        input  ready_out, valid_out, area_out, negative_out, tag_out, cull_count_out
    );
endinterface

// File: rtl/triangle_area_pipe.sv
// Four-stage doubled signed triangle area with valid/ready flow control, face/degenerate
// culling and a saturating cull counter. Counter-clockwise (top-left origin) is positive.
module triangle_area_pipe #(
    parameter int COORD_WIDTH     = 17,
    parameter int TAG_WIDTH       = 8,
    parameter int DROP_DEGENERATE = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    triangle_area_pipe_if.slave  bus
);
    localparam int PW = 2 * COORD_WIDTH;
    localparam int DW = 2 * COORD_WIDTH + 1;
    localparam int SW = 2 * COORD_WIDTH + 2;

    logic                    w_advance;
    logic                    w_xfer;

    logic                    r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic [TAG_WIDTH-1:0]    r_s1_tag, r_s2_tag, r_s3_tag;
    logic [1:0]              r_s1_mode, r_s2_mode, r_s3_mode;
    logic signed [SW-1:0]    r_s3_sum;

    logic [PW-1:0]           r_area;
    logic                    r_negative;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic [COUNT_WIDTH-1:0]  r_cull_count;

    logic                    w_s3_neg;
    logic                    w_s3_zero;
    logic [PW-1:0]           w_s3_mag;
    logic                    w_cull;
    logic                    w_cull_event;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_advance     = !r_s4_valid || bus.ready_in;
    assign w_xfer        = bus.valid_in && w_advance;
    assign bus.ready_out = w_advance;

    // Term gi pairs x[gi+1]*y[gi] against x[gi]*y[gi+1], giving the three cross differences.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_term
            localparam int NX = (gi + 1) % 3;
            logic [PW-1:0]        r_pa;
            logic [PW-1:0]        r_pb;
            logic signed [DW-1:0] r_d;

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_pa <= '0;
                    r_pb <= '0;
                    r_d  <= '0;
                end else if (w_advance) begin
                    r_pa <= PW'(bus.vertices_in[NX][0]) * PW'(bus.vertices_in[gi][1]);
                    r_pb <= PW'(bus.vertices_in[gi][0]) * PW'(bus.vertices_in[NX][1]);
                    r_d  <= $signed({1'b0, r_pa}) - $signed({1'b0, r_pb});
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
            r_s3_tag   <= '0;
            r_s1_mode  <= '0;
            r_s2_mode  <= '0;
            r_s3_mode  <= '0;
            r_s3_sum   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_xfer;
            r_s1_tag   <= bus.tag_in;
            r_s1_mode  <= bus.cull_mode_in;
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
            r_s2_mode  <= r_s1_mode;
            r_s3_valid <= r_s2_valid;
            r_s3_tag   <= r_s2_tag;
            r_s3_mode  <= r_s2_mode;
            r_s3_sum   <= {g_term[0].r_d[DW-1], g_term[0].r_d}
                        + {g_term[1].r_d[DW-1], g_term[1].r_d}
                        + {g_term[2].r_d[DW-1], g_term[2].r_d};
        end
    end

    // |sum| < 2^PW, so negating only the low PW bits yields the exact magnitude.
    assign w_s3_neg  = r_s3_sum[SW-1];
    assign w_s3_zero = (r_s3_sum == '0);
    assign w_s3_mag  = w_s3_neg ? (~r_s3_sum[PW-1:0] + PW'(1)) : r_s3_sum[PW-1:0];

    assign w_cull = (w_s3_neg && r_s3_mode[0])
                 || (!w_s3_neg && !w_s3_zero && r_s3_mode[1])
                 || (w_s3_zero && (DROP_DEGENERATE != 0));
    assign w_cull_event = w_advance && r_s3_valid && w_cull;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s4_valid <= 1'b0;
            r_area     <= '0;
            r_negative <= 1'b0;
            r_tag      <= '0;
        end else if (w_advance) begin
            r_s4_valid <= r_s3_valid && !w_cull;
            if (r_s3_valid && !w_cull) begin
                r_area     <= w_s3_mag;
                r_negative <= w_s3_neg;
                r_tag      <= r_s3_tag;
            end
        end
    end

    // Clear takes priority over a cull landing in the same cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cull_count <= '0;
        end else if (bus.clear_count_in) begin
            r_cull_count <= '0;
        end else if (w_cull_event && (r_cull_count != '1)) begin
            r_cull_count <= r_cull_count + COUNT_WIDTH'(1);
        end
    end

    assign bus.valid_out      = r_s4_valid;
    assign bus.area_out       = r_area;
    assign bus.negative_out   = r_negative;
    assign bus.tag_out        = r_tag;
    assign bus.cull_count_out = r_cull_count;
endmodule
